// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_divider_pkg;

  localparam int unsigned DEF_CNT_W = 28;
  // Legality is evaluated at this fixed width so any CNT_W up to 64 can share one struct.
  localparam int unsigned CFG_W = 64;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } div_cfg_t;

  function automatic logic cfg_legal(input div_cfg_t c);
    return (c.div >= CFG_W'(2)) && (c.high != '0) && (c.high < c.div);
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Configuration write port of the multi-channel clock divider.
interface clock_divider_multi_if
  import clock_divider_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag, output flops.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             align_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic [CNT_W-1:0] wr_high_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d, high_q, high_d;
  logic [CNT_W-1:0] sh_div_q, sh_high_q;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic             boundary;

  // Output flops are computed from next-cycle cnt/D/H so they always match cnt_q.
  always_comb begin
    boundary = !en_i || align_i || (cnt_q == div_q - CNT_W'(1));
    div_d    = div_q;
    high_d   = high_q;
    pend_d   = pend_q;
    if (pend_q && boundary) begin
      div_d  = sh_div_q;
      high_d = sh_high_q;
      pend_d = 1'b0;
    end
    if (wr_i) pend_d = 1'b1;
    cnt_d  = boundary ? '0 : cnt_q + CNT_W'(1);
    clk_d  = (cnt_d >= (div_d - high_d));
    tick_d = (cnt_d == (div_d - CNT_W'(1)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_q     <= RST_DIV;
      high_q    <= RST_HIGH;
      sh_div_q  <= RST_DIV;
      sh_high_q <= RST_HIGH;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      high_q <= high_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      if (wr_i) begin
        sh_div_q  <= wr_div_i;
        sh_high_q <= wr_high_i;
      end
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider; config handshake decode and cfg_err.
// Optional CLOCK_DIVIDER_SYNC_ALIGN_EN adds sync_align to restart all channels in phase.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [N_CH-1:0]       enable,
`ifdef CLOCK_DIVIDER_SYNC_ALIGN_EN
  input  logic                  sync_align,
`endif
  clock_divider_multi_if.slave  cfg,
  output logic [N_CH-1:0]       clock_out,
  output logic [N_CH-1:0]       tick
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;
  logic            ch_ok, accept, legal, align;
  logic            err_q;
  div_cfg_t        req;

`ifdef CLOCK_DIVIDER_SYNC_ALIGN_EN
  assign align = sync_align;
`else
  assign align = 1'b0;
`endif

  // Out-of-range channel numbers (non power-of-two N_CH) are never ready.
  always_comb begin
    req.div        = CFG_W'(cfg.cfg_div);
    req.high       = CFG_W'(cfg.cfg_high);
    legal          = cfg_legal(req);
    ch_ok          = (int'(cfg.cfg_ch) < int'(N_CH));
    cfg.cfg_ready  = !reset && ch_ok && !pend[cfg.cfg_ch];
    accept         = cfg.cfg_valid && cfg.cfg_ready;
    wr             = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr[i] = accept && legal && (cfg.cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept && !legal;
  end

  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clock_divider_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clock_in),
      .rst_i    (reset),
      .en_i     (enable[g]),
      .align_i  (align),
      .wr_i     (wr[g]),
      .wr_div_i (cfg.cfg_div),
      .wr_high_i(cfg.cfg_high),
      .pend_o   (pend[g]),
      .clk_o    (clock_out[g]),
      .tick_o   (tick[g])
    );
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (4 channels, 28-bit counters).
module tb_clock_divider_multi;
  logic       clock_in;
  logic       reset;
  logic [3:0] enable;
  logic       sync_align;
  logic [3:0] clock_out;
  logic [3:0] tick;
  int         n_cmp;
  int         n_err;

  logic [0:9]  p2_clk, p2_tick;
  logic [0:11] p3_clk, p3_tick, p3_rdy;
  logic [0:12] p5_clk, p5_tick, p5_rdy;

  clock_divider_multi_if #(.N_CH(4), .CNT_W(28)) cfg_if ();

  clock_divider_multi #(
    .N_CH       (4),
    .CNT_W      (28),
    .DEFAULT_DIV(2)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable),
`ifdef CLOCK_DIVIDER_SYNC_ALIGN_EN
    .sync_align(sync_align),
`endif
    .cfg      (cfg_if.slave),
    .clock_out(clock_out),
    .tick     (tick)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [27:0] d, input logic [27:0] h);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = d;
    cfg_if.cfg_high  = h;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    p2_clk  = 10'b0011000110;
    p2_tick = 10'b0001000010;
    p3_clk  = 12'b110000111100;
    p3_tick = 12'b010000000100;
    p3_rdy  = 12'b001111111111;
    p5_clk  = 13'b0000111100010;
    p5_tick = 13'b0000000100010;
    p5_rdy  = 13'b0000000011111;
    reset      = 1'b0;
    enable     = 4'b0000;
    sync_align = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;
    #2 reset = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_out", 0, 32'(clock_out), 32'h0);
    chk("rst_tick", 0, 32'(tick), 32'h0);
    chk("rst_err", 0, 32'(cfg_if.cfg_err), 32'h0);
    chk("rst_rdy", 0, 32'(cfg_if.cfg_ready), 32'h0);

    // Release with all channels running at the default D=2
    reset  = 1'b0;
    enable = 4'b1111;
    #1;
    chk("def_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    chk("def_out", 0, 32'(clock_out), 32'h0);
    step();
    chk("def_out", 1, 32'(clock_out), 32'hF);
    chk("def_tick", 1, 32'(tick), 32'hF);
    step();
    chk("def_out", 2, 32'(clock_out), 32'h0);
    chk("def_tick", 2, 32'(tick), 32'h0);
    step();
    chk("def_out", 3, 32'(clock_out), 32'hF);

    // ch1 D=5 H=2 written while disabled
    enable = 4'b1101;
    write(2'd1, 28'd5, 28'd2);
    #1;
    chk("w1_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("w1_rdy", 1, 32'(cfg_if.cfg_ready), 32'h0);
    chk("w1_out", 1, 32'(clock_out), 32'h0);
    step();
    chk("w1_rdy", 2, 32'(cfg_if.cfg_ready), 32'h1);
    chk("w1_out", 2, 32'(clock_out), 32'hD);
    chk("w1_tick", 2, 32'(tick), 32'hD);
    enable = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("d5_clk1", k, 32'(clock_out[1]), 32'(p2_clk[k]));
      chk("d5_tick1", k, 32'(tick[1]), 32'(p2_tick[k]));
      chk("d5_clk0", k, 32'(clock_out[0]), 32'(k % 2));
    end

    // ch1 D=5 -> D=8 H=4 written at cnt=2
    step();
    step();
    chk("pre_w2", 0, 32'(clock_out[1]), 32'h0);
    write(2'd1, 28'd8, 28'd4);
    #1;
    chk("w2_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    step();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = 2'd0;
    #1;
    chk("w2_rdy_ch0", 0, 32'(cfg_if.cfg_ready), 32'h1);
    cfg_if.cfg_ch = 2'd1;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      chk("d8_clk1", k, 32'(clock_out[1]), 32'(p3_clk[k]));
      chk("d8_tick1", k, 32'(tick[1]), 32'(p3_tick[k]));
      chk("d8_rdy1", k, 32'(cfg_if.cfg_ready), 32'(p3_rdy[k]));
    end

    // Illegal writes: H=D, then D=1 H=0 (ch1 at cnt=1 of D=8)
    write(2'd1, 28'd5, 28'd5);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("ill1_err", 0, 32'(cfg_if.cfg_err), 32'h1);
    chk("ill1_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    chk("ill1_clk1", 0, 32'(clock_out[1]), 32'h0);
    step();
    chk("ill1_err", 1, 32'(cfg_if.cfg_err), 32'h0);
    write(2'd1, 28'd1, 28'd0);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("ill2_err", 0, 32'(cfg_if.cfg_err), 32'h1);
    chk("ill2_clk1", 0, 32'(clock_out[1]), 32'h1);
    step();
    chk("ill2_err", 1, 32'(cfg_if.cfg_err), 32'h0);
    chk("ill2_rdy", 1, 32'(cfg_if.cfg_ready), 32'h1);
    step();
    step();
    chk("ill_tick1", 0, 32'(tick[1]), 32'h1);
    step();
    chk("ill_clk1", 0, 32'(clock_out[1]), 32'h0);

    // Write accepted in the boundary cycle (cnt=7 of D=8) -> D=4 H=1
    for (int k = 0; k < 7; k++) step();
    chk("bnd_tick1", 0, 32'(tick[1]), 32'h1);
    write(2'd1, 28'd4, 28'd1);
    #1;
    chk("bnd_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    step();
    cfg_if.cfg_valid = 1'b0;
    #1;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) step();
      chk("bnd_clk1", k, 32'(clock_out[1]), 32'(p5_clk[k]));
      chk("bnd_tick1", k, 32'(tick[1]), 32'(p5_tick[k]));
      chk("bnd_rdy1", k, 32'(cfg_if.cfg_ready), 32'(p5_rdy[k]));
    end

    // Reset mid-period with ch1 write pending
    step();
    write(2'd1, 28'd6, 28'd3);
    step();
    cfg_if.cfg_valid = 1'b0;
    #1;
    chk("mid_rdy", 0, 32'(cfg_if.cfg_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("mid_out", 0, 32'(clock_out), 32'h0);
    chk("mid_tick", 0, 32'(tick), 32'h0);
    chk("mid_rdy_rst", 0, 32'(cfg_if.cfg_ready), 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    chk("post_out", 0, 32'(clock_out), 32'h0);
    step();
    chk("post_out", 1, 32'(clock_out), 32'hF);
    chk("post_tick", 1, 32'(tick), 32'hF);
    step();
    chk("post_out", 2, 32'(clock_out), 32'h0);
    step();
    chk("post_out", 3, 32'(clock_out), 32'hF);

`ifdef CLOCK_DIVIDER_SYNC_ALIGN_EN
    // ch2 D=3 H=1 applied by a sync_align pulse, all channels restart together
    write(2'd2, 28'd3, 28'd1);
    #1;
    chk("sa_rdy", 0, 32'(cfg_if.cfg_ready), 32'h1);
    step();
    cfg_if.cfg_valid = 1'b0;
    sync_align = 1'b1;
    step();
    sync_align = 1'b0;
    #1;
    chk("sa_out", 0, 32'(clock_out), 32'h0);
    chk("sa_tick", 0, 32'(tick), 32'h0);
    chk("sa_rdy", 1, 32'(cfg_if.cfg_ready), 32'h1);
    step();
    chk("sa_out", 1, 32'(clock_out), 32'hB);
    chk("sa_tick", 1, 32'(tick), 32'hB);
    step();
    chk("sa_out", 2, 32'(clock_out), 32'h4);
    chk("sa_tick", 2, 32'(tick), 32'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
